// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan multiplexer.
// Snapshots the digit data once per frame so a display frame never tears.
module seg_scan_mux #(
    parameter int DIV = 50000,
    parameter int GAP = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic [6:0] iS1,
    input  logic [6:0] iS2,
    input  logic [6:0] iS3,
    input  logic [6:0] iS4,
    input  logic [3:0] iDp,
    input  logic [3:0] iBlank,
    output logic [6:0] oSeg,
    output logic       oDp,
    output logic [3:0] oAn,
    output logic       oFrame
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_idx;
    logic [6:0]    r_snap_seg [4];
    logic [3:0]    r_snap_dp;
    logic [3:0]    r_snap_blank;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_an;
    logic          r_frame;

    logic          w_last;
    logic          w_load;
    logic          w_off;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    // Slot bookkeeping and next-output decode from pre-edge state.
    always_comb begin
        w_last = (r_pcnt == PW'(DIV - 1));
        w_load = iEn & w_last & (r_idx == 2'd3);
        w_off  = ~iEn | (r_pcnt < PW'(GAP));
        w_an   = 4'hF;
        w_seg  = 7'h7F;
        w_dp   = 1'b1;
        if (!w_off) begin
            unique case (r_idx)
                2'd0:    w_an = 4'b1110;
                2'd1:    w_an = 4'b1101;
                2'd2:    w_an = 4'b1011;
                default: w_an = 4'b0111;
            endcase
            if (!r_snap_blank[r_idx]) begin
                w_seg = ~r_snap_seg[r_idx];
                w_dp  = ~r_snap_dp[r_idx];
            end
        end
    end

    // Prescaler and digit index advance only while scanning is enabled.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_pcnt <= '0;
            r_idx  <= 2'd0;
        end else if (iEn) begin
            if (w_last) begin
                r_pcnt <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_pcnt <= r_pcnt + PW'(1);
            end
        end
    end

    // Frame snapshot; reset state blanks every digit until the first load.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < 4; k++) begin
                r_snap_seg[k] <= 7'h00;
            end
            r_snap_dp    <= 4'h0;
            r_snap_blank <= 4'hF;
        end else if (w_load) begin
            r_snap_seg[0] <= iS1;
            r_snap_seg[1] <= iS2;
            r_snap_seg[2] <= iS3;
            r_snap_seg[3] <= iS4;
            r_snap_dp     <= iDp;
            r_snap_blank  <= iBlank;
        end
    end

    // Registered display outputs and frame-start pulse.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
            r_an    <= 4'hF;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg;
            r_dp    <= w_dp;
            r_an    <= w_an;
            r_frame <= w_load;
        end
    end

    assign oSeg   = r_seg;
    assign oDp    = r_dp;
    assign oAn    = r_an;
    assign oFrame = r_frame;

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIV, default 50000, meaning clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter GAP, default 16, meaning dead cycles at the start of each slot with all anodes off; legal range 1..DIV-2.
REQ-003 The port list SHALL be exactly the following; all anode and segment signals are active-low.
REQ-004 iClk  in  1  single system clock; all state changes on the rising edge.
REQ-005 iRst  in  1  asynchronous, active-high reset.
REQ-006 iEn  in  1  scan enable; 0 freezes scanning and darkens the display.
REQ-007 iS1, iS2, iS3, iS4  in  7 each  segment codes for the units, tens, hundreds and thousands digits.
REQ-008 iDp  in  4  decimal points; bit k belongs to digit k+1; 1 = lit.
REQ-009 iBlank  in  4  per-digit blank request; bit k belongs to digit k+1; 1 = dark.
REQ-010 oSeg  out  7  multiplexed segment bus; 7'h7F = all segments off.
REQ-011 oDp  out  1  multiplexed decimal point; 1 = off.
REQ-012 oAn  out  4  digit anodes; bit k selects digit k+1; 4'hF = all off.
REQ-013 oFrame  out  1  one-cycle pulse marking the start of a new frame.

Function
REQ-014 The block SHALL hold a prescaler pcnt (0..DIV-1) and a digit index idx (0..3).
REQ-015 When iEn=1, pcnt SHALL increment by one each cycle.
REQ-016 When iEn=1 and pcnt==DIV-1, pcnt SHALL go to 0 and idx SHALL go to idx+1 mod 4; idx 3 wraps to 0.
REQ-017 When iEn=0, pcnt and idx SHALL hold their values.
REQ-018 A snapshot SHALL load {iS1..iS4, iDp, iBlank} on the cycle where iEn=1, pcnt==DIV-1 and idx==3.
REQ-019 Display data SHALL come only from the snapshot, so an input change never tears a frame.
REQ-020 oFrame SHALL be registered and SHALL be 1 for exactly the one cycle after the snapshot load; otherwise 0.
REQ-021 oSeg, oDp and oAn SHALL be registered, each computed from the pre-edge values of pcnt, idx, iEn and the snapshot (one-cycle lag).
REQ-022 Off condition: if iEn=0 or pcnt<GAP, the outputs SHALL be oAn=4'hF, oSeg=7'h7F, oDp=1.
REQ-023 Otherwise oAn SHALL have only bit idx low, and oSeg/oDp SHALL be the inverted snapshot segment/DP code of digit idx+1.
REQ-024 If the snapshot blank bit for digit idx+1 is 1, that digit's anode SHALL stay low with oSeg=7'h7F and oDp=1.
REQ-025 At most one oAn bit SHALL be low in any cycle.
REQ-026 When iEn rises from 0 to 1, scanning SHALL resume from the held pcnt/idx with no slot restart.

Reset
REQ-027 While iRst=1, asynchronously: pcnt=0, idx=0, snapshot segment codes=7'h00, snapshot DP=0, snapshot blank=4'hF.
REQ-028 While iRst=1, the outputs SHALL be oSeg=7'h7F, oDp=1, oAn=4'hF, oFrame=0.
REQ-029 The display SHALL stay dark until the first snapshot load (first 4*DIV cycles after reset).
REQ-030 Reset asserted mid-slot SHALL take effect immediately and SHALL NOT require a clock edge.

Verification (DIV=8, GAP=2)
REQ-031 Basic scan:
- Stimulus: reset, iEn=1, iS1=7'h3F, iS2=7'h06, iS3=7'h5B, iS4=7'h4F, iDp=0, iBlank=0.
- Response: from the second frame onward, each slot shows 2 cycles oAn=F then 6 cycles oAn=E/D/B/7 in turn.
- Response: oSeg shows 7'h40, 7'h79, 7'h24, 7'h30 in the matching slots; the period is 32 cycles.
REQ-032 Frame pulse and tearing:
- Stimulus: change iS2 mid-frame.
- Response: oSeg is unchanged until the slot after the next oFrame pulse; oFrame is high 1 cycle in every 32.
REQ-033 Blank and DP:
- Stimulus: iBlank=4'b1000, iDp=4'b0010.
- Response: in the thousands slot, oAn=7 and oSeg=7'h7F; in the tens slot, oDp=0.
REQ-034 Enable freeze:
- Stimulus: drop iEn for 5 cycles mid-slot for digit 3.
- Response: the outputs go fully off during the hold; after iEn returns, the slot completes its remaining cycles with oAn=B.
REQ-035 Async reset:
- Stimulus: assert iRst between clock edges during an active slot.
- Response: oAn=F and oSeg=7'h7F immediately; after release, the first lit digit appears only after 32+2 cycles.
REQ-036 Assertion: over the whole run, oAn never has more than one zero bit.
